// File: rtl/apb_fifo_bridge_if.sv
// APB slave-side bus bundle for apb_fifo_bridge; signal names follow the AMBA APB naming.
interface apb_fifo_bridge_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_fifo_bridge.sv
// APB slave with TX/RX FIFOs between the bus and a byte-stream core (I2C engine).
// Define APB_FIFO_STALL_EN to stall full-TX writes / empty-RX reads instead of erroring.
module apb_fifo_bridge #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_fifo_bridge_if.slave  apb,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              irq
);
  localparam int TXP_W = $clog2(TX_DEPTH);
  localparam int RXP_W = $clog2(RX_DEPTH);
  localparam int TXC_W = TXP_W + 1;
  localparam int RXC_W = RXP_W + 1;
  localparam logic [TXP_W-1:0] TXP_ONE  = TXP_W'(1);
  localparam logic [RXP_W-1:0] RXP_ONE  = RXP_W'(1);
  localparam logic [TXC_W-1:0] TXC_ONE  = TXC_W'(1);
  localparam logic [RXC_W-1:0] RXC_ONE  = RXC_W'(1);
  localparam logic [TXC_W-1:0] TX_FULLC = TXC_W'(TX_DEPTH);
  localparam logic [RXC_W-1:0] RX_FULLC = RXC_W'(RX_DEPTH);

  localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_TXDATA = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_RXDATA = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_TXLVL  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_RXLVL  = ADDR_W'(5);

  typedef struct packed {
    logic ie_rxavail;
    logic ie_txempty;
    logic tx_en;
  } ctrl_t;

  ctrl_t ctrl;
  logic  rx_ovf;

  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [TXP_W-1:0]  tx_wr, tx_rd;
  logic [RXP_W-1:0]  rx_wr, rx_rd;
  logic [TXC_W-1:0]  tx_cnt;
  logic [RXC_W-1:0]  rx_cnt;

  logic tx_empty, tx_full, rx_empty, rx_full;
  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == TX_FULLC);
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == RX_FULLC);

  // ---- APB decode ----
  logic access, sel_ctrl, sel_status, sel_txdata, sel_rxdata, sel_txlvl, sel_rxlvl;
  logic mapped, ro_sel, tx_block, rx_block, err_c, pready, done, wr_ok, rd_ok;

  assign access     = apb.PSELx & apb.PENABLE;
  assign sel_ctrl   = (apb.PADDR == A_CTRL);
  assign sel_status = (apb.PADDR == A_STATUS);
  assign sel_txdata = (apb.PADDR == A_TXDATA);
  assign sel_rxdata = (apb.PADDR == A_RXDATA);
  assign sel_txlvl  = (apb.PADDR == A_TXLVL);
  assign sel_rxlvl  = (apb.PADDR == A_RXLVL);
  assign mapped     = sel_ctrl | sel_status | sel_txdata | sel_rxdata | sel_txlvl | sel_rxlvl;
  assign ro_sel     = sel_rxdata | sel_txlvl | sel_rxlvl;
  assign tx_block   = apb.PWRITE & sel_txdata & tx_full;
  assign rx_block   = ~apb.PWRITE & sel_rxdata & rx_empty;

`ifdef APB_FIFO_STALL_EN
  // Blocked FIFO accesses wait for space/data rather than failing.
  assign pready = ~(access & (tx_block | rx_block));
  assign err_c  = ~mapped | (apb.PWRITE & ro_sel);
`else
  assign pready = 1'b1;
  assign err_c  = ~mapped | (apb.PWRITE & ro_sel) | tx_block | rx_block;
`endif

  assign done        = access & pready;
  assign wr_ok       = done & ~err_c & apb.PWRITE;
  assign rd_ok       = done & ~err_c & ~apb.PWRITE;
  assign apb.PREADY  = pready;
  assign apb.PSLVERR = access & err_c;

  // ---- FIFO control ----
  logic tx_push, tx_pop, rx_push, rx_pop, tx_flush, rx_flush, ovf_set, ovf_clr, ctrl_wr;

  assign ctrl_wr  = wr_ok & sel_ctrl;
  assign tx_flush = ctrl_wr & apb.PWDATA[1];
  assign rx_flush = ctrl_wr & apb.PWDATA[2];
  assign ovf_clr  = wr_ok & sel_status & apb.PWDATA[4];
  assign tx_push  = wr_ok & sel_txdata;
  assign rx_pop   = rd_ok & sel_rxdata;
  assign tx_pop   = tx_valid & tx_ready;
  // A core push landing on the RX flush edge is discarded silently.
  assign rx_push  = rx_valid & rx_ready & ~rx_flush;
  assign ovf_set  = rx_valid & ~rx_ready;

  assign tx_valid = ctrl.tx_en & ~tx_empty;
  assign tx_data  = tx_valid ? tx_mem[tx_rd] : '0;
  assign rx_ready = ~rx_full;

  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wr] <= apb.PWDATA;
    if (rx_push) rx_mem[rx_wr] <= rx_data;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else if (tx_flush) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TXP_ONE;
      if (tx_pop)  tx_rd <= tx_rd + TXP_ONE;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + TXC_ONE;
        2'b01:   tx_cnt <= tx_cnt - TXC_ONE;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else if (rx_flush) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + RXP_ONE;
      if (rx_pop)  rx_rd <= rx_rd + RXP_ONE;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + RXC_ONE;
        2'b01:   rx_cnt <= rx_cnt - RXC_ONE;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // ---- Registers ----
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl   <= '0;
      rx_ovf <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl <= '{ie_rxavail: apb.PWDATA[4], ie_txempty: apb.PWDATA[3], tx_en: apb.PWDATA[0]};
      // A fresh overflow wins over a same-cycle clear so it is never lost.
      if (ovf_set)      rx_ovf <= 1'b1;
      else if (ovf_clr) rx_ovf <= 1'b0;
      irq <= (ctrl.ie_txempty & tx_empty) | (ctrl.ie_rxavail & ~rx_empty) | rx_ovf;
    end
  end

  // ---- Read mux ----
  always_comb begin
    apb.PRDATA = '0;
    if (rd_ok) begin
      case (1'b1)
        sel_ctrl:   apb.PRDATA[4:0] = {ctrl.ie_rxavail, ctrl.ie_txempty, 2'b00, ctrl.tx_en};
        sel_status: apb.PRDATA[4:0] = {rx_ovf, rx_full, rx_empty, tx_full, tx_empty};
        sel_rxdata: apb.PRDATA      = rx_mem[rx_rd];
        sel_txlvl:  apb.PRDATA      = DATA_W'(tx_cnt);
        sel_rxlvl:  apb.PRDATA      = DATA_W'(rx_cnt);
        default:    apb.PRDATA      = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_fifo_bridge.sv
// Directed bench for apb_fifo_bridge (default build, 8-bit data, 8-deep FIFOs).
module tb_apb_fifo_bridge;
  logic       PCLK = 1'b0;
  logic       PRESET;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] ldat;
  logic       lerr;

  apb_fifo_bridge_if #(.ADDR_W(7), .DATA_W(8)) apb ();

  apb_fifo_bridge #(.DATA_W(8), .ADDR_W(7), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(apb),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One APB transfer; cpush raises rx_valid on the completing edge only.
  task automatic xfer(input logic wr, input logic [6:0] addr, input logic [7:0] wdata, input logic cpush);
    int n;
    @(negedge PCLK);
    apb.PSELx = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = addr; apb.PWDATA = wdata;
    @(negedge PCLK);
    apb.PENABLE = 1'b1;
    #1;
    n = 0;
    while (!apb.PREADY && n < 50) begin
      @(negedge PCLK); #1; n++;
    end
    if (n >= 50) chk("pready_timeout", 32'(apb.PREADY), 32'd1);
    ldat = apb.PRDATA;
    lerr = apb.PSLVERR;
    if (cpush) rx_valid = 1'b1;
    @(posedge PCLK);
    #1;
    if (cpush) rx_valid = 1'b0;
    apb.PSELx = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic apb_wr(input logic [6:0] addr, input logic [7:0] d);
    xfer(1'b1, addr, d, 1'b0);
  endtask

  task automatic apb_rd(input logic [6:0] addr);
    xfer(1'b0, addr, 8'h00, 1'b0);
  endtask

  initial begin
    apb.PSELx = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = '0; apb.PWDATA = '0;
    tx_ready = 0; rx_valid = 0; rx_data = '0;
    PRESET = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;

    // Reset state
    chk("rst_prdata", 32'(apb.PRDATA), 0);
    chk("rst_pready", 32'(apb.PREADY), 1);
    chk("rst_pslverr", 32'(apb.PSLVERR), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_rx_ready", 32'(rx_ready), 1);
    chk("rst_irq", 32'(irq), 0);
    apb_rd(7'h01); chk("rst_status", 32'(ldat), 32'h05); chk("rst_status_err", 32'(lerr), 0);
    apb_rd(7'h00); chk("rst_ctrl", 32'(ldat), 0);

    // TX basic path
    apb_wr(7'h00, 8'h01);
    apb_wr(7'h02, 8'h55); chk("txw1_err", 32'(lerr), 0);
    apb_wr(7'h02, 8'hF5);
    chk("tx_valid_up", 32'(tx_valid), 1);
    apb_rd(7'h04); chk("txlvl_2", 32'(ldat), 2);
    @(negedge PCLK); tx_ready = 1'b1;
    chk("tx_head_55", 32'(tx_data), 32'h55);
    @(negedge PCLK);
    chk("tx_head_f5", 32'(tx_data), 32'hF5);
    @(negedge PCLK); tx_ready = 1'b0;
    chk("tx_valid_drained", 32'(tx_valid), 0);
    chk("tx_data_zero", 32'(tx_data), 0);
    apb_rd(7'h04); chk("txlvl_0", 32'(ldat), 0);
    apb_rd(7'h02); chk("txdata_reads0", 32'(ldat), 0); chk("txdata_rd_err", 32'(lerr), 0);

    // RX basic path
    @(negedge PCLK); rx_valid = 1'b1; rx_data = 8'hAA;
    @(negedge PCLK); rx_data = 8'hFA;
    @(negedge PCLK); rx_valid = 1'b0;
    apb_rd(7'h05); chk("rxlvl_2", 32'(ldat), 2);
    apb_rd(7'h03); chk("rx_aa", 32'(ldat), 32'hAA);
    apb_rd(7'h03); chk("rx_fa", 32'(ldat), 32'hFA);
    apb_rd(7'h01); chk("status_rx_empty", 32'(ldat), 32'h05);
    apb_rd(7'h03); chk("rx_empty_err", 32'(lerr), 1); chk("rx_empty_data", 32'(ldat), 0);

    // TX fill / overflow error
    for (int i = 0; i < 8; i++) apb_wr(7'h02, 8'(8'h10 + i));
    apb_rd(7'h04); chk("txlvl_full", 32'(ldat), 8);
    apb_rd(7'h01); chk("status_tx_full", 32'(ldat), 32'h06);
    apb_wr(7'h02, 8'hEE); chk("tx_full_err", 32'(lerr), 1);
    apb_rd(7'h04); chk("txlvl_still8", 32'(ldat), 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK); tx_ready = 1'b1;
      chk("tx_fill_head", 32'(tx_data), 32'(8'h10 + i));
    end
    @(negedge PCLK); tx_ready = 1'b0;
    chk("tx_head_13", 32'(tx_data), 32'h13);
    apb_rd(7'h04); chk("txlvl_5", 32'(ldat), 5);

    // TX flush
    apb_wr(7'h00, 8'h03);
    chk("flush_tx_valid", 32'(tx_valid), 0);
    apb_rd(7'h04); chk("flush_txlvl", 32'(ldat), 0);
    apb_rd(7'h00); chk("flush_ctrl_rb", 32'(ldat), 32'h01);

    // RX overflow and irq
    for (int i = 0; i < 9; i++) begin
      @(negedge PCLK); rx_valid = 1'b1; rx_data = 8'(8'hC0 + i);
    end
    @(negedge PCLK); rx_valid = 1'b0;
    chk("ovf_rx_ready", 32'(rx_ready), 0);
    chk("ovf_irq_lag", 32'(irq), 0);
    @(negedge PCLK);
    chk("ovf_irq", 32'(irq), 1);
    apb_rd(7'h05); chk("rxlvl_8", 32'(ldat), 8);
    apb_rd(7'h01); chk("status_ovf", 32'(ldat), 32'h19);
    apb_wr(7'h01, 8'h10);
    @(negedge PCLK); @(negedge PCLK);
    chk("ovf_irq_fall", 32'(irq), 0);
    apb_rd(7'h01); chk("status_ovf_clr", 32'(ldat), 32'h09);

    // Same-cycle APB pop and core push at level 3
    for (int i = 0; i < 5; i++) begin
      apb_rd(7'h03); chk("rx_drain", 32'(ldat), 32'(8'hC0 + i));
    end
    apb_rd(7'h05); chk("rxlvl_3", 32'(ldat), 3);
    rx_data = 8'hD0;
    xfer(1'b0, 7'h03, 8'h00, 1'b1); chk("rx_c5_concurrent", 32'(ldat), 32'hC5);
    apb_rd(7'h05); chk("rxlvl_stays3", 32'(ldat), 3);
    apb_rd(7'h03); chk("rx_c6", 32'(ldat), 32'hC6);
    apb_rd(7'h03); chk("rx_c7", 32'(ldat), 32'hC7);
    apb_rd(7'h03); chk("rx_d0_wrapped", 32'(ldat), 32'hD0);
    apb_rd(7'h05); chk("rxlvl_0", 32'(ldat), 0);

    // Interrupt enables
    apb_wr(7'h00, 8'h08);
    chk("ie_txe_lag", 32'(irq), 0);
    @(posedge PCLK); #1;
    chk("ie_txe_irq", 32'(irq), 1);
    apb_wr(7'h00, 8'h10);
    @(posedge PCLK); #1;
    chk("ie_rxa_idle", 32'(irq), 0);
    @(negedge PCLK); rx_valid = 1'b1; rx_data = 8'h3C;
    @(negedge PCLK); rx_valid = 1'b0;
    chk("ie_rxa_lag", 32'(irq), 0);
    @(negedge PCLK);
    chk("ie_rxa_irq", 32'(irq), 1);
    apb_rd(7'h03); chk("rx_3c", 32'(ldat), 32'h3C);
    apb_wr(7'h00, 8'h00);

    // Error decode
    apb_rd(7'h06); chk("unmapped_err", 32'(lerr), 1); chk("unmapped_data", 32'(ldat), 0);
    apb_rd(7'h40); chk("upper_bits_err", 32'(lerr), 1);
    apb_wr(7'h04, 8'h07); chk("wr_ro_err", 32'(lerr), 1);
    apb_wr(7'h03, 8'h07); chk("wr_rxdata_err", 32'(lerr), 1);
    apb_rd(7'h04); chk("wr_ro_nochange", 32'(ldat), 0);
    apb_rd(7'h00); chk("ctrl_ok_err", 32'(lerr), 0);

    // Reset in the middle of a transfer
    apb_wr(7'h00, 8'h01);
    apb_wr(7'h02, 8'h77);
    chk("pre_rst_tx_valid", 32'(tx_valid), 1);
    @(negedge PCLK);
    apb.PSELx = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = 7'h02; apb.PWDATA = 8'h99; PRESET = 1'b1;
    @(negedge PCLK); apb.PENABLE = 1'b1;
    @(negedge PCLK); apb.PSELx = 1'b0; apb.PENABLE = 1'b0; PRESET = 1'b0;
    chk("midrst_tx_valid", 32'(tx_valid), 0);
    apb_rd(7'h04); chk("midrst_txlvl", 32'(ldat), 0);
    apb_rd(7'h00); chk("midrst_ctrl", 32'(ldat), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/apb_fifo_bridge.md
# apb_fifo_bridge

Parametrised single-clock APB slave that buffers traffic between the APB bus and a byte-stream core (I2C engine) through independent TX and RX FIFOs. It generalises the fixed 8-bit APB-to-FIFO path: configurable data width and FIFO depths, a register map with control, status and level registers, sticky overflow, interrupt generation and APB error reporting. It sits between the APB interconnect and the I2C controller core, both in the PCLK domain.

## Interface
- DATA_W, 8: data width of PWDATA/PRDATA and both FIFOs; must be ≥ 8.
- ADDR_W, 7: PADDR width.
- TX_DEPTH, 8: TX FIFO entries; power of two, ≥ 2.
- RX_DEPTH, 8: RX FIFO entries; power of two, ≥ 2.
- PCLK  in  1  sole clock, all state on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- PSELx, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  ADDR_W  register address.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error.
- tx_data  out  DATA_W  TX FIFO head word (first-word-fall-through).
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  core pops TX when tx_valid & tx_ready.
- rx_data  in  DATA_W  word from core.
- rx_valid  in  1  core offers rx_data.
- rx_ready  out  1  RX has space; push when rx_valid & rx_ready.
- irq  out  1  level interrupt, registered.

## Operation
- Access completes on the PCLK edge where PSELx & PENABLE & PREADY; side effects (push/pop/register write) only on that edge.
- Register map (low bits, upper bits zero): 0x00 CTRL RW; 0x01 STATUS; 0x02 TXDATA WO (reads 0); 0x03 RXDATA RO; 0x04 TXLVL RO; 0x05 RXLVL RO.
- CTRL: bit0 TX_EN, bit1 TX_FLUSH, bit2 RX_FLUSH (both self-clear, read 0), bit3 IE_TXEMPTY, bit4 IE_RXAVAIL. Reset 0.
- STATUS: bit0 tx_empty, bit1 tx_full, bit2 rx_empty, bit3 rx_full, bit4 rx_ovf (sticky, write-1-to-clear); other bits ignore writes.
- rx_ovf sets on any cycle with rx_valid & ~rx_ready; the word is dropped.
- Levels: $clog2(DEPTH)+1 bits, range 0..DEPTH.
- tx_valid = TX_EN & ~tx_empty; tx_data = 0 when tx_valid is low.
- rx_ready = ~rx_full.
- irq next-cycle = (IE_TXEMPTY & tx_empty) | (IE_RXAVAIL & ~rx_empty) | rx_ovf.
- Write TXDATA when full, read RXDATA when empty, or any unmapped address / write to RO register: PSLVERR=1, no state change, read returns 0.
- Simultaneous APB push/pop and core pop/push on the same FIFO: both take effect, level unchanged; pointers wrap modulo depth.
- Flush vs same-cycle core action: TX pop on the flush edge completes, then FIFO empty; RX core push on the flush edge is discarded (no overflow).

## Timing
- Reset values: PRDATA 0, PREADY 1, PSLVERR 0, tx_data 0, tx_valid 0, rx_ready 1, irq 0, both FIFOs empty, CTRL 0, rx_ovf 0.
- PRDATA, PSLVERR combinational during access phase (PSELx & PENABLE), 0 otherwise.
- Zero-wait-state default: setup + access = 2 PCLK per transfer.
- Push visible in level/flags the cycle after the completing edge; tx_valid rises one cycle after TXDATA write if TX_EN=1.
- irq lags its causes by one cycle.
- PRESET mid-transfer: aborts transfer, all state to reset values next edge.

## Configuration
- APB_FIFO_STALL_EN defined: TXDATA write while tx_full and RXDATA read while rx_empty hold PREADY low (flags sampled registered) until space/data exists, then complete with PSLVERR=0; stall does not block core-side traffic. Undefined: PREADY tied 1, such accesses error per Operation.

## Test plan
- Reset, TX_EN=1, write TXDATA 0x55 then 0xF5 -> tx_valid=1, tx_data 0x55 then 0xF5 on pops, TXLVL 2→0.
- Core pushes 0xAA, 0xFA -> RXLVL=2; APB reads RXDATA -> 0xAA, 0xFA, rx_empty=1.
- Fill TX (8 writes), 9th write -> PSLVERR=1, TXLVL=8 (stall build: PREADY low until one pop, then completes, TXLVL=8).
- RX full plus rx_valid -> rx_ovf=1, irq=1 next cycle; write STATUS 0x10 -> rx_ovf=0, irq falls.
- Same-cycle APB RXDATA pop and core push at RXLVL=3 -> RXLVL stays 3, data order preserved.
- Write CTRL TX_FLUSH with TXLVL=5 -> TXLVL=0, tx_valid=0, CTRL reads TX_FLUSH=0.
